// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard/stall/flush controller; optional counters under PIPE_CTRL_PERF_EN
module pipe_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       branch_taken,
    input  logic       md_start,
    input  logic       md_done,
    input  logic       dmem_busy,
    output logic       pc_stall,
    output logic       hazard_ifid,
    output logic       stall_idex,
    output logic       stall_exmem,
    output logic       flush,
    output logic       flush_idex,
    output logic [1:0] state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MD_WAIT  = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;
    localparam logic [1:0] RESUME   = 2'd3;

    logic [1:0] state_d;
    logic       md_done_q;
    logic       md_done_d;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    always_comb begin
        pc_stall    = 1'b0;
        hazard_ifid = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        flush       = 1'b0;
        flush_idex  = 1'b0;
        state_d     = state;
        md_done_d   = md_done_q;
        case (state)
            RUN: begin
                if (dmem_busy) begin
                    pc_stall    = 1'b1;
                    hazard_ifid = 1'b1;
                    stall_idex  = 1'b1;
                    stall_exmem = 1'b1;
                    state_d     = MEM_WAIT;
                end else if (branch_taken) begin
                    // the instruction in ID is being squashed, so it cannot cause a load-use stall
                    flush      = 1'b1;
                    flush_idex = 1'b1;
                end else if (md_start) begin
                    pc_stall    = 1'b1;
                    hazard_ifid = 1'b1;
                    stall_idex  = 1'b1;
                    state_d     = MD_WAIT;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    hazard_ifid = 1'b1;
                    flush_idex  = 1'b1;
                end
            end
            MD_WAIT: begin
                pc_stall    = 1'b1;
                hazard_ifid = 1'b1;
                stall_idex  = 1'b1;
                stall_exmem = dmem_busy;
                if (md_done) md_done_d = 1'b1;
                if ((md_done || md_done_q) && !dmem_busy) begin
                    state_d   = RESUME;
                    md_done_d = 1'b0;
                end
            end
            MEM_WAIT: begin
                if (md_done) md_done_d = 1'b1;
                if (dmem_busy) begin
                    pc_stall    = 1'b1;
                    hazard_ifid = 1'b1;
                    stall_idex  = 1'b1;
                    stall_exmem = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        // outputs must drop while reset is held, regardless of clock
        if (!rst) begin
            pc_stall    = 1'b0;
            hazard_ifid = 1'b0;
            stall_idex  = 1'b0;
            stall_exmem = 1'b0;
            flush       = 1'b0;
            flush_idex  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            md_done_q <= 1'b0;
        end else begin
            state     <= state_d;
            md_done_q <= md_done_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 16'd0;
        end else begin
            if (pc_stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
            if (flush && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized and directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read;
    logic       branch_taken, md_start, md_done, dmem_busy;
    logic       pc_stall, hazard_ifid, stall_idex, stall_exmem, flush, flush_idex;
    logic [1:0] state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_state;
    bit m_mdq;
    int m_stalls;
    int m_flushes;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .md_start(md_start),
        .md_done(md_done), .dmem_busy(dmem_busy),
        .pc_stall(pc_stall), .hazard_ifid(hazard_ifid),
        .stall_idex(stall_idex), .stall_exmem(stall_exmem),
        .flush(flush), .flush_idex(flush_idex), .state(state)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    // {pc_stall, hazard_ifid, stall_idex, stall_exmem, flush, flush_idex}
    logic [5:0] dut_o;
    assign dut_o = {pc_stall, hazard_ifid, stall_idex, stall_exmem, flush, flush_idex};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural rules: which pipeline registers hold or clear, and where the FSM goes
    task automatic model_eval(output logic [5:0] o, output int nst, output bit nmdq);
        bit hazard;
        hazard = ex_mem_read && ex_rd != 0 &&
                 ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        o = 6'b0; nst = m_state; nmdq = m_mdq;
        if (m_state == 0) begin
            if (dmem_busy)          begin o = 6'b111100; nst = 2; end
            else if (branch_taken)  o = 6'b000011;
            else if (md_start)      begin o = 6'b111000; nst = 1; end
            else if (hazard)        o = 6'b110001;
        end else if (m_state == 1) begin
            o = {3'b111, dmem_busy, 2'b00};
            nmdq = m_mdq | md_done;
            if ((md_done || m_mdq) && !dmem_busy) begin nst = 3; nmdq = 0; end
        end else if (m_state == 2) begin
            nmdq = m_mdq | md_done;
            if (dmem_busy) o = 6'b111100;
            else nst = 0;
        end else begin
            nst = 0;
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_mdq = 0; m_stalls = 0; m_flushes = 0;
    endtask

    // Called at posedge+1; inputs already driven. Checks at negedge, advances model at next posedge.
    task automatic run_cycle(input string tag, input bit do_exp, input logic [5:0] exp_o, input logic [1:0] exp_s);
        logic [5:0] mo;
        int nst;
        bit nmdq;
        @(negedge clk);
        model_eval(mo, nst, nmdq);
        check({tag, "_outs"}, 32'(dut_o), 32'(mo));
        check({tag, "_state"}, 32'(state), 32'(m_state));
        if (do_exp) begin
            check({tag, "_outs_dir"}, 32'(dut_o), 32'(exp_o));
            check({tag, "_state_dir"}, 32'(state), 32'(exp_s));
        end
        @(posedge clk);
        if (mo[5]) m_stalls++;
        if (mo[1]) m_flushes++;
        m_state = nst; m_mdq = nmdq;
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rd = 0; ex_mem_read = 0; branch_taken = 0; md_start = 0;
        md_done = 0; dmem_busy = 0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        dmem_busy = 1'b1; branch_taken = 1'b1; md_start = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(dut_o), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        idle_inputs();
        rst = 1'b1;

        // load-use
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
        run_cycle("load_use", 1, 6'b110001, 2'd0);
        // branch over hazard
        branch_taken = 1;
        run_cycle("branch_hazard", 1, 6'b000011, 2'd0);
        idle_inputs();
        run_cycle("quiet", 1, 6'b000000, 2'd0);

        // divide: md_done six cycles after the start
        md_start = 1;
        run_cycle("md_start", 1, 6'b111000, 2'd0);
        for (int i = 0; i < 6; i++) begin
            md_done = (i == 5);
            run_cycle("md_wait", 1, 6'b111000, 2'd1);
        end
        md_done = 0; md_start = 0;
        run_cycle("md_resume", 1, 6'b000000, 2'd3);
        run_cycle("md_back", 1, 6'b000000, 2'd0);

        // early done while memory is busy
        md_start = 1;
        run_cycle("ed_start", 1, 6'b111000, 2'd0);
        dmem_busy = 1; md_done = 1;
        run_cycle("ed_pulse", 1, 6'b111100, 2'd1);
        md_done = 0;
        run_cycle("ed_busy", 1, 6'b111100, 2'd1);
        dmem_busy = 0;
        run_cycle("ed_drop", 1, 6'b111000, 2'd1);
        md_start = 0;
        run_cycle("ed_resume", 1, 6'b000000, 2'd3);

        // reset mid MEM_WAIT
        dmem_busy = 1;
        run_cycle("mw_enter", 1, 6'b111100, 2'd0);
        check("mw_state", 32'(state), 32'd2);
        rst = 1'b0;
        #1;
        check("mw_rst_outs", 32'(dut_o), 32'd0);
        check("mw_rst_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        check("mw_rst_hold", 32'(state), 32'd0);
        rst = 1'b1;
        model_reset();
        run_cycle("mw_after", 1, 6'b111100, 2'd0);
        dmem_busy = 0;
        run_cycle("mw_exit", 1, 6'b000000, 2'd2);

        // reset again, then 10 stall cycles and 3 flushes
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        dmem_busy = 1;
        for (int i = 0; i < 10; i++) run_cycle("perf_stall", 0, 6'b0, 2'd0);
        dmem_busy = 0;
        run_cycle("perf_exit", 1, 6'b000000, 2'd2);
        branch_taken = 1;
        for (int i = 0; i < 3; i++) run_cycle("perf_flush", 1, 6'b000011, 2'd0);
        branch_taken = 0;
        @(negedge clk);
        check("perf_model_stalls", 32'(m_stalls), 32'd10);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall_cycles", stall_cycles, 32'd10);
        check("perf_flush_count", 32'(flush_count), 32'd3);
`endif
        @(posedge clk);
        #1;

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            id_rs1_used  = 1'($urandom_range(0, 1));
            id_rs2_used  = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 5) == 0);
            md_start     = ($urandom_range(0, 5) == 0);
            md_done      = ($urandom_range(0, 4) == 0);
            dmem_busy    = ($urandom_range(0, 4) == 0);
            run_cycle("rand", 0, 6'b0, 2'd0);
        end
`ifdef PIPE_CTRL_PERF_EN
        @(negedge clk);
        check("rand_stall_cycles", stall_cycles, 32'(m_stalls));
        check("rand_flush_count", 32'(flush_count), 32'(m_flushes));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
